// File: rtl/booth4_pkg.sv
// ---------------------------------------------------------------------------
// booth4_pkg
// Shared definitions for the radix-4 Booth multiplier slice.
//   - state_t        : controller states FREE / ON / END
//   - booth_digit_t  : signed radix-4 digit in the range -2..+2
//   - width constants: operand (8), product (16), iterations (5), and the
//                      derived multiplicand / multiplier / accumulator widths
//   - scale_mcand()  : digit x multiplicand, sign-extended to accumulator width
// Used by booth4_mul and booth_encode. The optional overflow flag is enabled
// with the BOOTH4_MUL_OVF_EN macro in booth4_mul.
// ---------------------------------------------------------------------------
package booth4_pkg;

  localparam int OPERAND_W  = 8;
  localparam int PRODUCT_W  = 16;
  localparam int ITERATIONS = 5;

  // One guard bit so unsigned operands stay positive after sign extension.
  localparam int MCAND_W  = OPERAND_W + 1;
  // Extended multiplier plus the implicit zero below its LSB.
  localparam int MPLIER_W = OPERAND_W + 2;
  localparam int ACC_W    = 18;

  // Iteration counter runs ITERATIONS-1 down to 0.
  localparam logic [2:0] CNT_INIT = 3'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    ON   = 2'd1,
    END  = 2'd2
  } state_t;

  typedef logic signed [2:0] booth_digit_t;

  // Partial product for one Booth digit, already sign-extended to the
  // accumulator width so it can be added directly.
  function automatic logic [ACC_W-1:0] scale_mcand(input booth_digit_t digit,
                                                   input logic [MCAND_W-1:0] mcand);
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] res;
    ext = {{(ACC_W - MCAND_W){mcand[MCAND_W-1]}}, mcand};
    case (digit)
      3'sd1:   res = ext;
      3'sd2:   res = ext << 1;
      -3'sd1:  res = -ext;
      -3'sd2:  res = -(ext << 1);
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/booth_encode.sv
// ---------------------------------------------------------------------------
// booth_encode
// Combinational radix-4 Booth recoder: maps a multiplier triplet
// {y[2i+1], y[2i], y[2i-1]} onto a signed digit in -2..+2.
// Ports:
//   triplet : in  [2:0] multiplier bit triplet, MSB first
//   digit   : out booth_digit_t recoded signed digit
// ---------------------------------------------------------------------------
module booth_encode
  import booth4_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_t digit
);

  // Standard radix-4 recoding table; runs of equal bits contribute nothing.
  always_comb begin
    digit = 3'sd0;
    case (triplet)
      3'b000, 3'b111: digit = 3'sd0;
      3'b001, 3'b010: digit = 3'sd1;
      3'b011:         digit = 3'sd2;
      3'b100:         digit = -3'sd2;
      3'b101, 3'b110: digit = -3'sd1;
      default:        digit = 3'sd0;
    endcase
  end

endmodule

// File: rtl/booth4_mul.sv
// ---------------------------------------------------------------------------
// booth4_mul
// Sequential 8x8 radix-4 Booth multiplier, signed or unsigned per request.
// One request is accepted in FREE; five ON cycles retire one Booth digit each;
// END registers the product and pulses ready.
// Ports:
//   clock     : in  rising-edge clock
//   reset     : in  asynchronous active-high reset
//   start     : in  request, only honoured in FREE
//   is_signed : in  1 = two's-complement operands, 0 = unsigned
//   a, b      : in  [7:0] multiplicand / multiplier, sampled on acceptance
//   ready     : out one-cycle pulse when p carries a new product
//   busy      : out high whenever the controller is not in FREE
//   p         : out [15:0] product, held until the next accepted request
//   ovf       : out product does not fit in 8 bits (only with macro
//               BOOTH4_MUL_OVF_EN defined)
// ---------------------------------------------------------------------------
module booth4_mul
  import booth4_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic                 ready,
  output logic                 busy,
  output logic [PRODUCT_W-1:0] p
`ifdef BOOTH4_MUL_OVF_EN
  ,
  output logic                 ovf
`endif
);

  state_t                     state;
  logic [2:0]                 cnt;
  logic [MCAND_W-1:0]         mcand;
  logic [MPLIER_W-1:0]        mreg;
  logic [ACC_W-1:0]           acc;
  logic [2:0]                 triplet;
  booth_digit_t               digit;
  logic [ACC_W-1:0]           acc_sum;
  logic signed [ACC_W+MPLIER_W-1:0] pair_next;

  assign busy = (state != FREE);

  // The accumulator and multiplier shift as one register pair, so by the last
  // digit the top of mreg already holds product bits. That last triplet needs
  // y9, which is just the sign of the extended multiplier (y8), so it is
  // rebuilt from the two multiplier bits still in place.
  assign triplet = (cnt == 3'd0) ? {mreg[1], mreg[1:0]} : mreg[2:0];

  booth_encode u_encode (
    .triplet (triplet),
    .digit   (digit)
  );

  // Add the digit's partial product into the upper half, then shift the pair
  // right by one radix-4 position, keeping the sign.
  assign acc_sum   = acc + scale_mcand(digit, mcand);
  assign pair_next = $signed({acc_sum, mreg}) >>> 2;

`ifdef BOOTH4_MUL_OVF_EN
  logic                         sign_r;
  logic [ACC_W-1:0]             product_full;

  // After five shifts the full 18-bit product sits across acc[7:0] and mreg.
  assign product_full = {acc[7:0], mreg};

  // Overflow flag: signed products must fit -128..127, unsigned 0..255.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_r <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (state == FREE && start) begin
        sign_r <= is_signed;
      end
      if (state == END) begin
        if (sign_r) begin
          ovf <= !((&product_full[ACC_W-1:7]) || (~|product_full[ACC_W-1:7]));
        end else begin
          ovf <= |product_full[ACC_W-1:8];
        end
      end
    end
  end
`endif

  // Controller and datapath: capture operands on acceptance, iterate five
  // digits in ON, publish the product and pulse ready from END.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FREE;
      cnt   <= CNT_INIT;
      ready <= 1'b0;
      p     <= '0;
      acc   <= '0;
      mcand <= '0;
      mreg  <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        FREE: begin
          if (start) begin
            mcand <= {(is_signed & a[OPERAND_W-1]), a};
            mreg  <= {(is_signed & b[OPERAND_W-1]), b, 1'b0};
            acc   <= '0;
            cnt   <= CNT_INIT;
            state <= ON;
          end
        end
        ON: begin
          {acc, mreg} <= pair_next;
          if (cnt == 3'd0) begin
            state <= END;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        END: begin
          p     <= {acc[5:0], mreg};
          ready <= 1'b1;
          cnt   <= CNT_INIT;
          state <= FREE;
        end
        default: begin
          state <= FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_mul.sv
// ---------------------------------------------------------------------------
// tb_booth4_mul
// Directed, table-driven bench for booth4_mul plus hand-written sequences for
// request collisions, mid-operation reset and back-to-back requests.
// ---------------------------------------------------------------------------
module tb_booth4_mul;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        busy;
  logic [15:0] p;
`ifdef BOOTH4_MUL_OVF_EN
  logic        ovf;
`endif

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  booth4_mul dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .p         (p)
`ifdef BOOTH4_MUL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Present a request at a falling edge; returns 1ns after the acceptance edge.
  task automatic applyStimulus(input logic sgn, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clock);
    is_signed = sgn;
    a         = av;
    b         = bv;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("accepted_busy", {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) for ready, then check latency, product and the pulse width.
  task automatic checkResult(input string name, input logic [15:0] exp_p, input logic exp_ovf);
    int cycles;
    cycles = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        cycles = k;
        break;
      end
    end
    checkOutput({name, "_latency"}, cycles, 32'd6);
    checkOutput({name, "_p"}, {16'd0, p}, {16'd0, exp_p});
`ifdef BOOTH4_MUL_OVF_EN
    checkOutput({name, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("[TB] note: %s expected ovf unknown", name);
`endif
    checkOutput({name, "_busy_at_ready"}, {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    checkOutput({name, "_ready_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    int pulses;
    int ready_k;
    logic [15:0] pv;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{1'b0, 8'd255,  8'd255,  16'hFE01, 1'b1};
    vecs[1]  = '{1'b1, 8'h80,   8'h80,   16'h4000, 1'b1};
    vecs[2]  = '{1'b1, 8'hFB,   8'd3,    16'hFFF1, 1'b0};
    vecs[3]  = '{1'b1, 8'd7,    8'hFF,   16'hFFF9, 1'b0};
    vecs[4]  = '{1'b0, 8'd0,    8'd200,  16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 8'd12,   8'd12,   16'h0090, 1'b0};
    vecs[6]  = '{1'b1, 8'd127,  8'd127,  16'h3F01, 1'b1};
    vecs[7]  = '{1'b0, 8'd16,   8'd15,   16'h00F0, 1'b0};
    vecs[8]  = '{1'b1, 8'hFF,   8'hFF,   16'h0001, 1'b0};
    vecs[9]  = '{1'b1, 8'h80,   8'h7F,   16'hC080, 1'b1};
    vecs[10] = '{1'b0, 8'h80,   8'd2,    16'h0100, 1'b1};
    vecs[11] = '{1'b1, 8'hF0,   8'd8,    16'hFF80, 1'b0};
    vecs[12] = '{1'b1, 8'd16,   8'd8,    16'h0080, 1'b1};
    vecs[13] = '{1'b0, 8'd15,   8'd17,   16'h00FF, 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    #1;
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_p", {16'd0, p}, 32'd0);
`ifdef BOOTH4_MUL_OVF_EN
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Table: first entry is accepted on the first edge after reset release.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
      checkResult($sformatf("vec%0d", i), vecs[i].exp_p, vecs[i].exp_ovf);
    end

    // Start pulses and new operands while ON must not disturb 10 x 20.
    applyStimulus(1'b0, 8'd10, 8'd20);
    pulses  = 0;
    ready_k = 0;
    pv      = 16'd0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 2) begin
        @(negedge clock);
        start     = 1'b1;
        is_signed = 1'b1;
        a         = 8'hFF;
        b         = 8'hFF;
      end else if (k == 3) begin
        @(negedge clock);
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (ready) begin
        pulses++;
        ready_k = k;
        pv      = p;
      end
    end
    checkOutput("ignore_pulses", pulses, 32'd1);
    checkOutput("ignore_latency", ready_k, 32'd6);
    checkOutput("ignore_p", {16'd0, pv}, 32'h00C8);

    // Reset during the third ON cycle aborts the operation silently.
    applyStimulus(1'b1, 8'h80, 8'h80);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, ready}, 32'd0);
    checkOutput("abort_p", {16'd0, p}, 32'd0);
`ifdef BOOTH4_MUL_OVF_EN
    checkOutput("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (ready) pulses++;
    end
    checkOutput("abort_no_ready", pulses, 32'd0);
    applyStimulus(1'b0, 8'd12, 8'd12);
    checkResult("after_abort", 16'h0090, 1'b0);

    // Start held high: one result every 7 cycles.
    @(negedge clock);
    is_signed = 1'b0;
    a         = 8'd3;
    b         = 8'd5;
    start     = 1'b1;
    pulses    = 0;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        pulses++;
        checkOutput($sformatf("held_pulse%0d_edge", pulses), k, 7 * pulses);
        checkOutput($sformatf("held_pulse%0d_p", pulses), {16'd0, p}, 32'h000F);
`ifdef BOOTH4_MUL_OVF_EN
        checkOutput($sformatf("held_pulse%0d_ovf", pulses), {31'd0, ovf}, 32'd0);
`endif
      end
    end
    start = 1'b0;
    checkOutput("held_pulse_count", pulses, 32'd5);

    repeat (10) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
